// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
package ram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  localparam int MAX_READ_LATENCY = 2;

  function automatic bit lat_ok(input int lat);
    return (lat >= 1) && (lat <= MAX_READ_LATENCY);
  endfunction

endpackage

// File: rtl/ram_array.sv
// Plain word storage: one write port and one registered read port.
module ram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register only moves on an accepted read so it holds the last word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with self-clearing and req/ready handshake.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 5,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  clear,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  if (!lat_ok(READ_LATENCY)) begin : g_bad_lat
    $error("ram_sync_param: READ_LATENCY must be 1 or 2");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  v1_q, v1_d;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    arr_we    = 1'b0;
    arr_waddr = address;
    arr_wdata = data;
    rd_acc    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        arr_we    = 1'b1;
        arr_waddr = clr_ptr_q;
        arr_wdata = INIT_VALUE;
        if (clr_ptr_q == LAST) begin
          state_d = ST_READY;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        // clear wins over any request in the same cycle
        if (clear) begin
          state_d   = ST_INIT;
          clr_ptr_d = '0;
        end else if (req) begin
          arr_we = wren;
          rd_acc = !wren;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = '0;
      end
    endcase
  end

  always_comb begin
    v1_d = rd_acc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
      v1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      v1_q      <= v1_d;
    end
  end

  assign ready     = (state_q == ST_READY);
  assign init_done = (state_q == ST_READY);

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clock),
    .rst   (reset),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (rd_acc),
    .raddr (address),
    .rdata (rdata)
  );

  if (READ_LATENCY == 1) begin : g_lat1
    assign q       = rdata;
    assign q_valid = v1_q;
  end else begin : g_lat2
    logic                  v2_q, v2_d;
    logic [DATA_WIDTH-1:0] q2_q, q2_d;

    always_comb begin
      v2_d = v1_q;
      q2_d = q2_q;
      if (v1_q) begin
        q2_d = rdata;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v2_q <= 1'b0;
        q2_q <= '0;
      end else begin
        v2_q <= v2_d;
        q2_q <= q2_d;
      end
    end

    assign q       = q2_q;
    assign q_valid = v2_q;
  end

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed bench for ram_sync_param: init, latency, clear and reset cases.
module tb_ram_sync_param;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic       req = 1'b0, wren = 1'b0, clear = 1'b0;
  logic [4:0] address = '0;
  logic [7:0] data = '0;
  logic       ready, q_valid, init_done;
  logic [7:0] q;

  logic        req1 = 1'b0, wren1 = 1'b0, clear1 = 1'b0;
  logic [3:0]  address1 = '0;
  logic [15:0] data1 = '0;
  logic        ready1, q_valid1, init_done1;
  logic [15:0] q1;

  logic       ready2, q_valid2, init_done2;
  logic [7:0] q2;

  int tests = 0;
  int fails = 0;
  int n, n1;
  logic seen;

  always #5 clock = ~clock;

  ram_sync_param dut0 (
    .clock(clock), .reset(reset), .req(req), .wren(wren),
    .address(address), .data(data), .clear(clear),
    .ready(ready), .q(q), .q_valid(q_valid), .init_done(init_done)
  );

  ram_sync_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2), .INIT_VALUE(16'h0)
  ) dut1 (
    .clock(clock), .reset(reset), .req(req1), .wren(wren1),
    .address(address1), .data(data1), .clear(clear1),
    .ready(ready1), .q(q1), .q_valid(q_valid1), .init_done(init_done1)
  );

  ram_sync_param #(
    .READ_LATENCY(2)
  ) dut2 (
    .clock(clock), .reset(reset), .req(req), .wren(wren),
    .address(address), .data(data), .clear(clear),
    .ready(ready2), .q(q2), .q_valid(q_valid2), .init_done(init_done2)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_ready1", 32'(ready1), 0);

    // requests held during init must be ignored
    req = 1; wren = 1; address = 5'd2; data = 8'hFF;
    req1 = 1; wren1 = 1; address1 = 4'd2; data1 = 16'hFFFF;
    reset = 0;
    n = 0;
    n1 = 0;
    while (!ready && n < 100) begin
      tick;
      n++;
      if (ready1 && n1 == 0) begin
        n1 = n;
        req1 = 0;
        wren1 = 0;
      end
    end
    req = 0; wren = 0;
    chk("init_cycles", 32'(n), 32);
    chk("init_done", 32'(init_done), 1);
    chk("init_cycles_l2", 32'(n1), 16);
    chk("init_ready2", 32'(ready2), 1);

    for (int i = 0; i < 32; i++) begin
      address = 5'(i);
      req = 1;
      tick;
      chk("clr_rd", 32'({q_valid, q}), 32'h100);
    end
    req = 0;
    tick;
    chk("idle_qv", 32'(q_valid), 0);

    req = 1; wren = 1; address = 5'd1; data = 8'h03;
    tick;
    chk("wr_no_qv", 32'(q_valid), 0);
    address = 5'd3; data = 8'h08;
    tick;
    wren = 0; address = 5'd1;
    tick;
    chk("rd1", 32'({q_valid, q}), 32'h103);
    address = 5'd3;
    tick;
    chk("rd3", 32'({q_valid, q}), 32'h108);
    req = 0;
    tick;
    chk("hold_q", 32'({q_valid, q}), 32'h008);

    req = 1; wren = 1; address = 5'd9; data = 8'h5A;
    tick;
    wren = 0;
    tick;
    chk("raw", 32'({q_valid, q}), 32'h15A);
    req = 0;
    tick;

    req1 = 1; wren1 = 1; address1 = 4'd7; data1 = 16'hBEEF;
    tick;
    wren1 = 0;
    tick;
    req1 = 0;
    chk("l2_qv_early", 32'(q_valid1), 0);
    tick;
    chk("l2_rd", 32'({q_valid1, q1}), 32'h1BEEF);
    tick;
    chk("l2_qv_end", 32'(q_valid1), 0);
    chk("l2_hold", 32'(q1), 32'hBEEF);

    req = 1; wren = 1; address = 5'd5; data = 8'hAA;
    tick;
    wren = 0;
    tick;
    chk("pre_clr_rd", 32'({q_valid, q}), 32'h1AA);
    clear = 1; req = 1; wren = 0; address = 5'd5;
    tick;
    clear = 0; req = 0;
    chk("clr_drop_qv", 32'(q_valid), 0);
    chk("clr_ready", 32'(ready), 0);
    chk("clr_init_done", 32'(init_done), 0);
    n = 0;
    while (!ready && n < 100) begin
      tick;
      n++;
    end
    chk("clr_cycles", 32'(n), 32);
    req = 1; address = 5'd5;
    tick;
    req = 0;
    chk("post_clr_rd", 32'({q_valid, q}), 32'h100);
    tick;

    req = 1; wren = 1; address = 5'd4; data = 8'h3C;
    tick;
    wren = 0;
    tick;
    req = 0;
    tick;
    chk("l2b_rd", 32'({q_valid2, q2}), 32'h13C);
    tick;

    req = 1; wren = 0; address = 5'd4;
    tick;
    req = 0;
    reset = 1;
    #1;
    chk("mid_rst_q", 32'(q2), 0);
    chk("mid_rst_ready", 32'(ready2), 0);
    seen = q_valid2;
    tick;
    seen = seen | q_valid2;
    tick;
    seen = seen | q_valid2;
    reset = 0;
    n = 0;
    while (!ready2 && n < 100) begin
      tick;
      n++;
      seen = seen | q_valid2;
    end
    chk("mid_rst_noqv", 32'(seen), 0);
    chk("reinit_cycles", 32'(n), 32);
    chk("reinit_q", 32'(q2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_sync_param.md
Name: ram_sync_param

Overview:
Parametrised single-port synchronous RAM. It is the next-generation storage primitive for the memory-hierarchy labs.
- Configurable width, depth and read latency (1 or 2 cycles).
- Automatic clearing of the array after reset or on command.
- req/ready handshake with a q_valid strobe.
- Sits below the cache/controller blocks as the backing main-memory model.

Parameters:
DATA_WIDTH, 8, bits per word
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH (localparam, not overridable)
READ_LATENCY, 1, cycles from accepted read to q_valid; legal values 1 or 2, any other value is an elaboration error
INIT_VALUE, 0, word written to every location during clearing

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
req  input  1  request strobe; accepted on a rising edge when req && ready
wren  input  1  1 = write, 0 = read; sampled with req
address  input  ADDR_WIDTH  word address
data  input  DATA_WIDTH  write data
clear  input  1  synchronous pulse; re-clears the whole array
ready  output  1  block accepts requests this cycle
q  output  DATA_WIDTH  read data; holds last read value
q_valid  output  1  one-cycle strobe, q is new this cycle
init_done  output  1  high once the array has been cleared since the last reset or clear

Behaviour:
- Reset (asynchronous, active-high): state=ST_INIT, clr_ptr=0, q=0, q_valid=0, ready=0, init_done=0. The read pipeline is flushed.
- ST_INIT:
  - Each cycle writes INIT_VALUE to mem[clr_ptr], then clr_ptr++.
  - After the write of DEPTH-1, the next state is ST_READY.
  - Clearing takes exactly DEPTH cycles after reset deasserts; ready rises on cycle DEPTH+1.
  - ready=0 throughout; req is ignored, not queued.
  - clear is ignored in this state.
- ST_READY:
  - ready=1, init_done=1.
  - Write: on an edge with req&&wren, mem[address]<=data. No q_valid.
  - Read: on an edge with req&&!wren, the array is read at that edge, so it sees every previously accepted write.
    - READ_LATENCY=1: q and q_valid update on that same edge and are visible the following cycle.
    - READ_LATENCY=2: one extra register stage.
  - Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
  - A write at cycle N followed by a read of the same address at N+1 returns the new data.
- clear in ST_READY:
  - At the next edge: state=ST_INIT, clr_ptr=0, ready=0, init_done=0.
  - A req in the same cycle as clear is dropped, with clear taking priority.
  - Reads already in the pipeline still complete and deliver their pre-clear data with q_valid.
- q_valid is 0 in every cycle with no completing read. q is not zeroed between reads.
- Reset mid-operation: in-flight reads are discarded (no q_valid) and a full re-clear follows.
- Address width equals log2(DEPTH), so there is no out-of-range case.
- clr_ptr is ADDR_WIDTH bits wide. Wrap-around is not used; the end of clearing is detected by comparing clr_ptr against DEPTH-1.

Decomposition:
- Package ram_pkg:
  - state enum: ST_INIT, ST_READY.
  - constant MAX_READ_LATENCY=2.
  - helper function checking READ_LATENCY legality.
- Sub-module ram_array:
  - Plain DATA_WIDTH x DEPTH storage with one write port (we, waddr, wdata) and a synchronous read (raddr, rdata).
  - The top-level block muxes between the clear port and the user port, and owns the FSM and the latency pipeline.

Test Plan:
- Init timing (defaults): release reset at cycle 0 → ready=0 for 32 cycles, ready=1 and init_done=1 from cycle 33; reading all 32 addresses returns 8'h00.
- Write/read, READ_LATENCY=1: write 8'h03 to 5'd1 and 8'h08 to 5'd3, then read 1 and 3 back-to-back → q=8'h03 then 8'h08 on consecutive cycles, each with a q_valid pulse one cycle after acceptance.
- READ_LATENCY=2, DATA_WIDTH=16, ADDR_WIDTH=4: write 16'hBEEF to addr 7, read in the next cycle → q_valid exactly 2 cycles after acceptance, q=16'hBEEF; 16-cycle init observed.
- Requests during init: hold req=1, wren=1, address=2, data=8'hFF during ST_INIT → after init, read addr 2 returns INIT_VALUE (0).
- Clear: write 8'hAA to addr 5, issue a read of 5 and pulse clear in the next cycle → the read delivers 8'hAA with q_valid; ready drops for 32 cycles; reading 5 afterwards returns 8'h00.
- Reset mid-read, READ_LATENCY=2: assert reset one cycle after a read is accepted → q_valid never pulses, q=0, and a full 32-cycle re-init follows.
